// File: rtl/norm_shift64_pkg.sv
// rtl/norm_shift64_pkg.sv - shared widths and stage payload for the normaliser
package norm_shift64_pkg;

  localparam int DATA_W = 64;
  localparam int SH_W   = 7;
  localparam int EXP_W  = 11;

  // In S1 the sh field carries the raw 6-bit count; in S2 it is the applied shift.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SH_W-1:0]   sh;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              uflow;
  } stage_t;

endpackage

// File: rtl/norm_shift_core.sv
// rtl/norm_shift_core.sv - combinational clamp-and-shift between S1 and S2
module norm_shift_core
  import norm_shift64_pkg::*;
(
  input  stage_t s1Stage,
  output stage_t s2Stage
);

  logic [5:0]      lzc;
  logic            clamp;
  logic [SH_W-1:0] shAmt;

  // Shift is the leading-zero count, limited so the exponent never goes below zero.
  always_comb begin
    lzc   = s1Stage.sh[5:0];
    clamp = ({{(EXP_W-6){1'b0}}, lzc} > s1Stage.exp);
    shAmt = clamp ? s1Stage.exp[SH_W-1:0] : {1'b0, lzc};
    s2Stage = '0;
    if (s1Stage.zero) begin
      s2Stage.zero = 1'b1;
    end else begin
      s2Stage.data  = s1Stage.data << shAmt;
      s2Stage.sh    = shAmt;
      s2Stage.exp   = s1Stage.exp - {{(EXP_W-SH_W){1'b0}}, shAmt};
      s2Stage.uflow = clamp;
    end
  end

endmodule

// File: rtl/norm_shift64.sv
// rtl/norm_shift64.sv - two-stage normalising left shifter with valid/ready handshake
module norm_shift64
  import norm_shift64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [7:0]        in_lzc,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SH_W-1:0]   out_shift,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow
);

  stage_t s1Q;
  stage_t s2Q;
  stage_t coreOut;
  logic   s1Valid;
  logic   s2Valid;
  logic   s2Load;
  logic   inXfer;

  // S2 can take new content when empty or when its result leaves this cycle.
  assign s2Load   = !s2Valid || out_ready;
  assign in_ready = !s1Valid || s2Load;
  assign inXfer   = in_valid && in_ready;

  norm_shift_core u_core (
    .s1Stage (s1Q),
    .s2Stage (coreOut)
  );

  // S1: capture operand, raw count and exponent; zero is detected locally since the LZC reports 0 for zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Q     <= '0;
    end else begin
      if (in_ready) s1Valid <= in_valid;
      if (inXfer) begin
        s1Q.data  <= in_data;
        s1Q.sh    <= {1'b0, in_lzc[5:0]};
        s1Q.exp   <= in_exp;
        s1Q.zero  <= ~|in_data;
        s1Q.uflow <= 1'b0;
      end
    end
  end

  // S2: hold the shifted result; payload only changes when a valid S1 entry moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2Q     <= '0;
    end else if (s2Load) begin
      s2Valid <= s1Valid;
      if (s1Valid) s2Q <= coreOut;
    end
  end

  assign out_valid = s2Valid;
  assign out_data  = s2Q.data;
  assign out_shift = s2Q.sh;
  assign out_exp   = s2Q.exp;
  assign out_zero  = s2Q.zero;
  assign out_uflow = s2Q.uflow;

endmodule

// File: tb/tb_norm_shift64.sv
// tb/tb_norm_shift64.sv - self-checking bench for norm_shift64
module tb_norm_shift64;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  shift;
    logic [10:0] exp;
    logic        zero;
    logic        uflow;
  } res_t;

  typedef struct {
    logic [63:0] inData;
    logic [7:0]  inLzc;
    logic [10:0] inExp;
    res_t        want;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_lzc = '0;
  logic [10:0] in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [6:0]  out_shift;
  logic [10:0] out_exp;
  logic        out_zero;
  logic        out_uflow;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  bit monOn   = 0;
  res_t expQ[$];
  int inCount, outCount, firstIn, firstOut, lastOut;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  norm_shift64 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lzc(in_lzc), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shift(out_shift), .out_exp(out_exp), .out_zero(out_zero),
    .out_uflow(out_uflow)
  );

  function automatic res_t model(input logic [63:0] d, input logic [7:0] l, input logic [10:0] e);
    res_t r;
    int cnt, ex, sh;
    r = '{default: '0};
    if (d == 64'd0) begin
      r.zero = 1'b1;
    end else begin
      cnt = int'(l) % 64;
      ex  = int'(e);
      sh  = (cnt < ex) ? cnt : ex;
      r.data  = d << sh;
      r.shift = 7'(sh);
      r.exp   = 11'(ex - sh);
      r.uflow = (cnt > ex);
    end
    return r;
  endfunction

  function automatic logic [7:0] clz(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) if (d[i]) return 8'(63 - i);
    return 8'd0;
  endfunction

  function automatic logic [95:0] packRes(input res_t r);
    return {12'd0, r.data, r.shift, r.exp, r.zero, r.uflow};
  endfunction

  function automatic logic [95:0] packOut();
    return {12'd0, out_data, out_shift, out_exp, out_zero, out_uflow};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: inputs accepted at a negedge are pushed; each output transfer pops the oldest.
  always @(negedge clk) begin
    if (monOn && !rst) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          check("unexpected_output", 96'd1, 96'd0);
        end else begin
          check("scoreboard", packOut(), packRes(expQ.pop_front()));
        end
        if (outCount == 0) firstOut = cyc;
        lastOut = cyc;
        outCount++;
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(in_data, in_lzc, in_exp));
        if (inCount == 0) firstIn = cyc;
        inCount++;
      end
    end
  end

  task automatic newOp(input bit randomMode);
    logic [63:0] d;
    d = {$urandom, $urandom} >> $urandom_range(63);
    if ($urandom_range(15) == 0) d = 64'd0;
    in_data = d;
    in_lzc  = {2'($urandom), 6'd0} | clz(d);
    if (randomMode && $urandom_range(7) == 0) in_lzc = 8'($urandom);
    in_exp  = ($urandom_range(1) == 0) ? 11'($urandom_range(70)) : 11'($urandom);
  endtask

  task automatic resetCounters();
    inCount = 0; outCount = 0; firstIn = -1; firstOut = -1; lastOut = -1;
    expQ.delete();
  endtask

  // Drives n operands; mode 0 = continuous valid/ready, mode 1 = random valid and backpressure.
  task automatic runStream(input int n, input int mode);
    int idx = 0;
    int guard = 0;
    bit adv = 0;
    newOp(mode == 1);
    while (outCount < n && guard < 20 * n + 50) begin
      @(posedge clk); #1;
      if (adv) begin newOp(mode == 1); adv = 0; end
      in_valid  = (idx < n) && (mode == 0 || $urandom_range(3) != 0);
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin idx++; adv = 1; end
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stream_complete", 96'(outCount), 96'(n));
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{64'h0000_0000_0000_00F0, 8'd56,   11'd100,  '{64'hF000_0000_0000_0000, 7'd56, 11'd44,   1'b0, 1'b0}});
    vecs.push_back('{64'h0,                   8'd0,    11'd500,  '{64'h0,                   7'd0,  11'd0,    1'b1, 1'b0}});
    vecs.push_back('{64'h1,                   8'd63,   11'd5,    '{64'h20,                  7'd5,  11'd0,    1'b0, 1'b1}});
    vecs.push_back('{64'h0000_0000_0000_0010, 8'd59,   11'd0,    '{64'h10,                  7'd0,  11'd0,    1'b0, 1'b1}});
    vecs.push_back('{64'h8000_0000_0000_0001, 8'd0,    11'd7,    '{64'h8000_0000_0000_0001, 7'd0,  11'd7,    1'b0, 1'b0}});
    vecs.push_back('{64'h0F00_0000_0000_0000, 8'hC4,   11'd20,   '{64'hF000_0000_0000_0000, 7'd4,  11'd16,   1'b0, 1'b0}});
    vecs.push_back('{64'h0000_0000_0000_0100, 8'd55,   11'd55,   '{64'h8000_0000_0000_0000, 7'd55, 11'd0,    1'b0, 1'b0}});
    vecs.push_back('{64'h1,                   8'd63,   11'd2047, '{64'h8000_0000_0000_0000, 7'd63, 11'd1984, 1'b0, 1'b0}});
    vecs.push_back('{64'h0,                   8'd63,   11'd2047, '{64'h0,                   7'd0,  11'd0,    1'b1, 1'b0}});

    // Reset state
    #2;
    check("reset_out_valid", 96'(out_valid), 96'd0);
    check("reset_in_ready",  96'(in_ready),  96'd1);
    check("reset_outputs",   packOut(),      96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed vectors, one at a time, with a 2-cycle latency check
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_data  = vecs[i].inData;
      in_lzc   = vecs[i].inLzc;
      in_exp   = vecs[i].inExp;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1_valid", i), 96'(out_valid), 96'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_lat2_valid", i), 96'(out_valid), 96'd1);
      check($sformatf("vec%0d_result", i), packOut(), packRes(vecs[i].want));
      @(posedge clk); #1;
      check($sformatf("vec%0d_drained", i), 96'(out_valid), 96'd0);
    end

    // Back-to-back throughput
    monOn = 1;
    resetCounters();
    runStream(10, 0);
    check("tput_first_latency", 96'(firstOut - firstIn), 96'd2);
    check("tput_consecutive",   96'(lastOut - firstOut), 96'd9);

    // Backpressure: 4 operands, out_ready held low for 4 cycles
    resetCounters();
    begin
      res_t first;
      int acc = 0;
      int guard = 0;
      bit adv = 0;
      newOp(0);
      first = model(in_data, in_lzc, in_exp);
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (adv) begin newOp(0); adv = 0; end
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        if (c >= 2) begin
          check("bp_in_ready_low", 96'(in_ready), 96'd0);
          check("bp_accepted_two", 96'(acc),      96'd2);
          check("bp_out_valid",    96'(out_valid), 96'd1);
          check("bp_out_stable",   packOut(),      packRes(first));
        end
        if (in_valid && in_ready) begin acc++; adv = 1; end
      end
      while (outCount < 4 && guard < 40) begin
        @(posedge clk); #1;
        if (adv) begin newOp(0); adv = 0; end
        in_valid  = (acc < 4);
        out_ready = 1'b1;
        @(negedge clk);
        if (in_valid && in_ready) begin acc++; adv = 1; end
        guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_all_delivered", 96'(outCount), 96'd4);
    end

    // Random traffic with random backpressure
    resetCounters();
    runStream(300, 1);
    check("rand_queue_empty", 96'(expQ.size()), 96'd0);

    // Reset mid-stream with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h0000_00FF_0000_0000;
    in_lzc    = 8'd24;
    in_exp    = 11'd300;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pre_full", {94'd0, out_valid, in_ready}, {94'd0, 1'b1, 1'b0});
    rst = 1'b1;
    #1;
    check("rst_async_valid",    96'(out_valid), 96'd0);
    check("rst_async_outputs",  packOut(),      96'd0);
    check("rst_async_in_ready", 96'(in_ready),  96'd1);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ignores_inputs", 96'(out_valid), 96'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    begin
      int stale = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("rst_no_stale", 96'(stale), 96'd0);
    end
    monOn = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
